i2c_ball_master: RTL and testbench



---
 rtl/i2c_ball_master_if.sv | 22 ++
 rtl/i2c_ball_master.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_ball_master.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_ball_master_if.sv
// Game-logic side of the ball master: transfer request, latched ball-state bytes, status back.
interface i2c_ball_master_if;
   logic       start;
   logic [7:0] y0;
   logic [7:0] y1;
   logic [7:0] yspeed;
   logic [7:0] gravity;
   logic [7:0] ballspeed;
   logic       busy;
   logic       done;
   logic       ack_err;

   modport master (
      input  start, y0, y1, yspeed, gravity, ballspeed,
      output busy, done, ack_err
   );

   modport slave (
      output start, y0, y1, yspeed, gravity, ballspeed,
      input  busy, done, ack_err
   );
endinterface

// File: rtl/i2c_ball_master.sv
// I2C write master: START, addr+W, five ball-state bytes, STOP; one transaction per accepted start.
// Optional I2C_RETRY_EN: on NACK, STOP + one idle bit, then restart up to MAX_RETRY times.
module i2c_ball_master #(
   parameter int         CLK_FREQ   = 100_000_000,
   parameter int         I2C_FREQ   = 100_000,
   parameter logic [6:0] SLAVE_ADDR = 7'h5A
`ifdef I2C_RETRY_EN
   ,parameter int        MAX_RETRY  = 3
`endif
) (
   input  logic              clk,
   input  logic              reset,
   i2c_ball_master_if.master bus,
   output logic              SCL,
   inout  wire               SDA
);
   localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
   localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [7:0] ADDR_W = {SLAVE_ADDR, 1'b0};

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP, S_WAIT, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [QW-1:0]     qcnt_q, qcnt_d;
   logic [1:0]        phase_q, phase_d;
   logic [2:0]        bit_q, bit_d;
   logic [2:0]        idx_q, idx_d;
   logic [4:0][7:0]   data_q, data_d;
   logic              ack_err_q, ack_err_d;
   logic              nack_q, nack_d;
   logic              scl_q, scl_d;
   logic              sda_oe_q, sda_oe_d;
   logic              sda_meta_q, sda_meta_d;
   logic              sda_sync_q, sda_sync_d;
`ifdef I2C_RETRY_EN
   logic [1:0]        retry_q, retry_d;
`endif

   logic       busy_w;
   logic       tick;
   logic       last_qtr;
   logic       mid_bit;
   logic [7:0] cur_data;

   assign busy_w   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign tick     = (qcnt_q == QW'(QTR - 1));
   assign last_qtr = tick && (phase_q == 2'd3);
   assign mid_bit  = (phase_q == 2'd1) || (phase_q == 2'd2);
   assign cur_data = data_q[idx_q];

   always_comb begin
      state_d    = state_q;
      qcnt_d     = '0;
      phase_d    = phase_q;
      bit_d      = bit_q;
      idx_d      = idx_q;
      data_d     = data_q;
      ack_err_d  = ack_err_q;
      nack_d     = nack_q;
      sda_meta_d = SDA;
      sda_sync_d = sda_meta_q;
`ifdef I2C_RETRY_EN
      retry_d    = retry_q;
`endif
      if (busy_w) begin
         qcnt_d = tick ? '0 : qcnt_q + QW'(1);
         if (tick) phase_d = phase_q + 2'd1;
      end

      case (state_q)
         S_IDLE: if (bus.start) begin
            state_d   = S_START;
            data_d    = {bus.ballspeed, bus.gravity, bus.yspeed, bus.y1, bus.y0};
            ack_err_d = 1'b0;
            nack_d    = 1'b0;
            phase_d   = 2'd0;
            bit_d     = 3'd0;
`ifdef I2C_RETRY_EN
            retry_d   = 2'd0;
`endif
         end
         // START is only three quarters long, so the phase is realigned by hand.
         S_START: if (tick && phase_q == 2'd2) begin
            state_d = S_ADDR;
            phase_d = 2'd0;
            bit_d   = 3'd0;
         end
         S_ADDR, S_DATA: if (last_qtr) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
         end
         S_ADDR_ACK, S_DATA_ACK: begin
            if (tick && phase_q == 2'd2) nack_d = sda_sync_q;
            if (last_qtr) begin
               if (nack_q) begin
                  state_d = S_STOP;
`ifdef I2C_RETRY_EN
                  if (retry_q == 2'(MAX_RETRY)) ack_err_d = 1'b1;
`else
                  ack_err_d = 1'b1;
`endif
               end else if (state_q == S_ADDR_ACK) begin
                  state_d = S_DATA;
                  idx_d   = 3'd0;
               end else if (idx_q == 3'd4) begin
                  state_d = S_STOP;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_DATA;
               end
            end
         end
         S_STOP: if (last_qtr) begin
`ifdef I2C_RETRY_EN
            // A NACK without ack_err means attempts remain.
            if (nack_q && !ack_err_q) begin
               state_d = S_WAIT;
               retry_d = retry_q + 2'd1;
            end else begin
               state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
         end
`ifdef I2C_RETRY_EN
         S_WAIT: if (last_qtr) state_d = S_START;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      scl_d    = 1'b1;
      sda_oe_d = 1'b0;
      case (state_q)
         S_START: begin
            scl_d    = (phase_q < 2'd2);
            sda_oe_d = 1'b1;
         end
         S_ADDR: begin
            scl_d    = mid_bit;
            sda_oe_d = ~ADDR_W[3'd7 - bit_q];
         end
         S_DATA: begin
            scl_d    = mid_bit;
            sda_oe_d = ~cur_data[3'd7 - bit_q];
         end
         S_ADDR_ACK, S_DATA_ACK: scl_d = mid_bit;
         S_STOP: begin
            scl_d    = (phase_q != 2'd0);
            sda_oe_d = (phase_q < 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         qcnt_q     <= '0;
         phase_q    <= 2'd0;
         bit_q      <= 3'd0;
         idx_q      <= 3'd0;
         data_q     <= '0;
         ack_err_q  <= 1'b0;
         nack_q     <= 1'b0;
         scl_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
`ifdef I2C_RETRY_EN
         retry_q    <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         ack_err_q  <= ack_err_d;
         nack_q     <= nack_d;
         scl_q      <= scl_d;
         sda_oe_q   <= sda_oe_d;
         sda_meta_q <= sda_meta_d;
         sda_sync_q <= sda_sync_d;
`ifdef I2C_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   assign SCL         = scl_q;
   assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
   assign bus.busy    = busy_w;
   assign bus.done    = (state_q == S_DONE);
   assign bus.ack_err = ack_err_q;
endmodule

// File: tb/tb_i2c_ball_master.sv
// Bench for i2c_ball_master: bus-decoding slave model plus table-driven transactions and corner sequences.
module tb_i2c_ball_master;
   localparam int CLK_FREQ = 1600;
   localparam int I2C_FREQ = 100;
`ifdef I2C_RETRY_EN
   localparam int NACK_ATTEMPTS = 4;
`else
   localparam int NACK_ATTEMPTS = 1;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic scl;
   wire  sda;
   logic slv_drv = 1'b0;

   pullup (sda);
   assign sda = slv_drv ? 1'b0 : 1'bz;

   i2c_ball_master_if bus ();

   i2c_ball_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .SLAVE_ADDR(7'h5A)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .SCL   (scl),
      .SDA   (sda)
   );

   always #5 clk = ~clk;

   // Slave model: decodes START/STOP/bytes from the pins and ACKs unless told to NACK byte nack_at.
   logic [7:0] rx [0:15];
   logic [7:0] sh = 8'h00;
   int  rx_cnt = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0, bitn = 0;
   int  nack_at = -1;
   bit  in_xfer = 0, acking = 0;
   logic prev_scl = 1'b1, prev_sda = 1'b1;

   always @(negedge clk) begin
      if (reset) begin
         in_xfer = 0; acking = 0; slv_drv = 1'b0; bitn = 0;
      end else if (prev_scl && scl && prev_sda && !sda) begin
         start_cnt++; in_xfer = 1; acking = 0; bitn = 0; rx_cnt = 0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
         stop_cnt++; in_xfer = 0;
      end else if (in_xfer && !prev_scl && scl && bitn < 8) begin
         sh = {sh[6:0], sda}; bitn++;
      end else if (in_xfer && prev_scl && !scl) begin
         if (acking) begin
            slv_drv = 1'b0; acking = 0; bitn = 0;
         end else if (bitn == 8 && rx_cnt < 16) begin
            rx[rx_cnt] = sh;
            slv_drv = (rx_cnt != nack_at);
            rx_cnt++;
            acking = 1;
         end
      end
      if (bus.done) done_cnt++;
      prev_scl = scl;
      prev_sda = sda;
   end

   int checks = 0, errors = 0;
   int base_start, base_stop, base_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic begin_txn(input logic [4:0][7:0] d, input int nack);
      nack_at = nack;
      bus.y0 = d[0]; bus.y1 = d[1]; bus.yspeed = d[2]; bus.gravity = d[3]; bus.ballspeed = d[4];
      base_start = start_cnt; base_stop = stop_cnt; base_done = done_cnt;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy_after_accept", bus.busy, 1'b1);
      check("ack_err_clear_on_accept", bus.ack_err, 1'b0);
   endtask

   task automatic finish_txn();
      logic seen = 1'b0;
      logic prev_busy = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (bus.done) begin seen = 1'b1; break; end
         prev_busy = bus.busy;
      end
      check("done_seen", seen, 1'b1);
      if (seen) begin
         check("busy_low_with_done", bus.busy, 1'b0);
         check("busy_high_before_done", prev_busy, 1'b1);
      end
      for (int i = 0; i < 10; i++) tick();
      check("single_done", done_cnt - base_done, 1);
   endtask

   task automatic check_bytes(input logic [4:0][7:0] d, input int n);
      logic [7:0] exp;
      check("nbytes", rx_cnt, n);
      for (int i = 0; i < n && i < 6; i++) begin
         exp = (i == 0) ? 8'hB4 : d[i-1];
         check($sformatf("byte%0d", i), rx[i], exp);
      end
   endtask

   typedef struct {
      logic [4:0][7:0] d;
      int              nack_at;
      int              exp_bytes;
      logic            exp_err;
      int              exp_starts;
   } vec_t;

   vec_t vecs [4];
   logic [4:0][7:0] orig, junk;
   logic reached;

   initial begin
      vecs[0] = '{ {8'h07, 8'h02, 8'h05, 8'h34, 8'h12}, -1, 6, 1'b0, 1 };
      vecs[1] = '{ {8'h07, 8'h02, 8'h05, 8'h34, 8'h12},  0, 1, 1'b1, NACK_ATTEMPTS };
      vecs[2] = '{ {8'h07, 8'h02, 8'h05, 8'h34, 8'h12},  3, 4, 1'b1, NACK_ATTEMPTS };
      vecs[3] = '{ {8'h01, 8'h80, 8'h00, 8'hFF, 8'hA5}, -1, 6, 1'b0, 1 };

      bus.start = 1'b0;
      bus.y0 = 8'h00; bus.y1 = 8'h00; bus.yspeed = 8'h00; bus.gravity = 8'h00; bus.ballspeed = 8'h00;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      check("idle_scl", scl, 1'b1);
      check("idle_sda", sda, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_done", bus.done, 1'b0);
      check("idle_ack_err", bus.ack_err, 1'b0);

      for (int v = 0; v < 4; v++) begin
         begin_txn(vecs[v].d, vecs[v].nack_at);
         finish_txn();
         check_bytes(vecs[v].d, vecs[v].exp_bytes);
         check("ack_err", bus.ack_err, vecs[v].exp_err);
         check("starts", start_cnt - base_start, vecs[v].exp_starts);
         check("stops", stop_cnt - base_stop, vecs[v].exp_starts);
         for (int i = 0; i < 20; i++) tick();
      end

      // start while busy is ignored, and mid-transfer input changes are not sent
      orig = {8'h0F, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
      begin_txn(orig, -1);
      for (int i = 0; i < 300; i++) tick();
      bus.y0 = 8'hFF; bus.y1 = 8'hFF; bus.yspeed = 8'hFF; bus.gravity = 8'hFF; bus.ballspeed = 8'hFF;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      finish_txn();
      check_bytes(orig, 6);
      for (int i = 0; i < 200; i++) tick();
      check("no_queued_start", start_cnt - base_start, 1);
      check("idle_after_ignored_start", bus.busy, 1'b0);

      // reset in the middle of the second data byte
      junk = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      begin_txn(junk, -1);
      reached = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (rx_cnt == 2) begin reached = 1'b1; break; end
      end
      check("reached_data_byte2", reached, 1'b1);
      for (int i = 0; i < 48; i++) tick();
      reset = 1'b1;
      tick();
      check("rst_scl", scl, 1'b1);
      check("rst_sda", sda, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) tick();
      check("rst_no_done", done_cnt - base_done, 0);
      check("rst_still_idle", bus.busy, 1'b0);

      begin_txn(vecs[0].d, -1);
      finish_txn();
      check_bytes(vecs[0].d, 6);
      check("after_rst_ack_err", bus.ack_err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
